// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizes and pointer/count types for the 16x4 FIFO
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_DATA_WIDTH = 4;
  localparam int FIFO_DEPTH      = 2**FIFO_ADDR_WIDTH;

  // One extra MSB on pointers distinguishes a full lap from empty.
  typedef logic [FIFO_ADDR_WIDTH:0] fifo_ptr_t;
  typedef logic [FIFO_ADDR_WIDTH:0] fifo_cnt_t;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-around FIFO pointer register with increment enable
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = FIFO_ADDR_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Advance by one when enabled; all-ones rolls to zero and flips the lap bit.
  always_comb begin
    ptr_d = ptr_q + {{(W-1){1'b0}}, inc};
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, flag, count and error controller for the FIFO memory
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AF_CNT = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT = AE_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] count_d;
  logic                overflow_q;
  logic                overflow_d;
  logic                underflow_q;
  logic                underflow_d;
  logic                rd_valid_q;
  logic                rd_valid_d;
  logic                wr_acc;
  logic                rd_acc;

  fifo_ptr #(.W(ADDR_WIDTH + 1)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wptr)
  );

  fifo_ptr #(.W(ADDR_WIDTH + 1)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rptr)
  );

  // Flags decode from registered pointers/count only, never from this cycle's requests.
  always_comb begin
    full         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    empty        = (wptr == rptr);
    almost_full  = (count_q >= AF_CNT);
    almost_empty = (count_q <= AE_CNT);
  end

  // Accept gating; memory strobes are blocked outright while reset is held.
  always_comb begin
    wr_acc  = push & ~full;
    rd_acc  = pop & ~empty;
    mem_wen = wr_acc & ~rst;
    mem_ren = rd_acc & ~rst;
  end

  // Next-state for occupancy, sticky errors (set beats clear) and read-valid delay.
  always_comb begin
    count_d     = count_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
    overflow_d  = (overflow_q & ~clr_err) | (push & full);
    underflow_d = (underflow_q & ~clr_err) | (pop & empty);
    rd_valid_d  = rd_acc;
  end

  // Controller state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign mem_waddr = wptr[ADDR_WIDTH-1:0];
  assign mem_raddr = rptr[ADDR_WIDTH-1:0];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - scoreboard bench for fifo_ctrl with a behavioural 16x4 memory
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] wdata = 4'h0;

  logic [3:0] mem_waddr;
  logic [3:0] mem_raddr;
  logic       mem_wen;
  logic       mem_ren;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  always #5 clk = ~clk;

  fifo_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .mem_waddr    (mem_waddr),
    .mem_raddr    (mem_raddr),
    .mem_wen      (mem_wen),
    .mem_ren      (mem_ren),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Behavioural dual-port memory: registered read, zero on non-read cycles.
  logic [3:0] mem [16];
  logic [3:0] rdata = 4'h0;
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= wdata;
    rdata <= mem_ren ? mem[mem_raddr] : 4'h0;
  end

  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] m_q[$];
  logic [3:0] exp_q[$];
  bit         m_ov = 1'b0;
  bit         m_uf = 1'b0;
  logic [3:0] mon_e;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected read data whenever the DUT flags rd_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rdata", int'(rdata), int'(mon_e));
        end
      end
      chk("count_vs_ptrs", int'(count[3:0]), int'(4'(mem_waddr - mem_raddr)));
    end
  end

  // One clock of stimulus, entered and left at 1 time unit after a rising edge.
  task automatic cycle(input bit p, input bit q, input bit c, input logic [3:0] d);
    bit mf, me, wa, ra;
    mf = (m_q.size() == 16);
    me = (m_q.size() == 0);
    wa = p && !mf;
    ra = q && !me;
    push = p; pop = q; clr_err = c; wdata = d;
    #1;
    chk("mem_wen", int'(mem_wen), int'(wa));
    chk("mem_ren", int'(mem_ren), int'(ra));
    m_ov = (m_ov && !c) || (p && mf);
    m_uf = (m_uf && !c) || (q && me);
    if (ra) exp_q.push_back(m_q.pop_front());
    if (wa) m_q.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    chk("count", int'(count), m_q.size());
    chk("full", int'(full), int'(m_q.size() == 16));
    chk("empty", int'(empty), int'(m_q.size() == 0));
    chk("almost_full", int'(almost_full), int'(m_q.size() >= 14));
    chk("almost_empty", int'(almost_empty), int'(m_q.size() <= 2));
    chk("overflow", int'(overflow), int'(m_ov));
    chk("underflow", int'(underflow), int'(m_uf));
    chk("rd_valid", int'(rd_valid), int'(ra));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_unf", int'(underflow), 0);
    chk("rst_rdv", int'(rd_valid), 0);
    chk("rst_waddr", int'(mem_waddr), 0);
    chk("rst_raddr", int'(mem_raddr), 0);

    // Fill
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'(i));
      chk("fill_count", int'(count), i + 1);
      if (i == 12) chk("af_at_13", int'(almost_full), 0);
      if (i == 13) chk("af_at_14", int'(almost_full), 1);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_waddr_wrap", int'(mem_waddr), 0);
    cycle(1'b1, 1'b0, 1'b0, 4'hF);
    chk("push17_ovf", int'(overflow), 1);
    chk("push17_count", int'(count), 16);

    // Drain
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'h0);
      if (i == 12) chk("ae_at_3", int'(almost_empty), 0);
      if (i == 13) chk("ae_at_2", int'(almost_empty), 1);
    end
    chk("drain_empty", int'(empty), 1);
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    chk("pop_empty_unf", int'(underflow), 1);
    chk("pop_empty_rdv", int'(rd_valid), 0);
    chk("pop_empty_rdata", int'(rdata), 0);

    // Clear errors
    cycle(1'b0, 1'b0, 1'b1, 4'h0);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_unf", int'(underflow), 0);

    // Concurrent push/pop at count 5
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 1'b0, 4'(i));
    chk("conc_waddr0", int'(mem_waddr), 5);
    chk("conc_raddr0", int'(mem_raddr), 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 4'(i + 6));
      chk("conc_count", int'(count), 5);
    end
    chk("conc_waddr", int'(mem_waddr), 9);
    chk("conc_raddr", int'(mem_raddr), 4);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 4'h0);

    // Collision at full
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 4'(i + 3));
    cycle(1'b1, 1'b1, 1'b0, 4'h7);
    chk("full_coll_count", int'(count), 15);
    chk("full_coll_ovf", int'(overflow), 1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, 4'h0);

    // Collision at empty
    cycle(1'b1, 1'b1, 1'b0, 4'hA);
    chk("empty_coll_count", int'(count), 1);
    chk("empty_coll_unf", int'(underflow), 1);
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    chk("empty_coll_rdata", int'(rdata), 10);

    // Clear coinciding with a new overflow
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 4'(15 - i));
    cycle(1'b1, 1'b0, 1'b1, 4'h0);
    chk("clr_set_ovf", int'(overflow), 1);
    chk("clr_set_unf", int'(underflow), 0);

    // Reset mid-stream with a read in flight
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 4'h0);
    chk("pre_rst_count", int'(count), 7);
    chk("pre_rst_rdv", int'(rd_valid), 1);
    push = 1'b1; pop = 1'b1; rst = 1'b1;
    exp_q.delete(); m_q.delete(); m_ov = 1'b0; m_uf = 1'b0;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_rdv", int'(rd_valid), 0);
    chk("mid_rst_wen", int'(mem_wen), 0);
    chk("mid_rst_ren", int'(mem_ren), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    @(posedge clk);
    #1 rst = 1'b0; push = 1'b0; pop = 1'b0;

    // Recovery after reset
    cycle(1'b1, 1'b0, 1'b0, 4'hC);
    cycle(1'b1, 1'b0, 1'b0, 4'hD);
    cycle(1'b1, 1'b0, 1'b0, 4'hE);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 1'b0, 4'h0);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
